// File: rtl/imem_fetch_if.sv
// Fetch-stage bus: the instruction-memory port plus the decode-side and
// execute-side signals of the 17-bit-instruction CPU fetch stage.
interface imem_fetch_if;
  logic [15:0] iaddr;
  logic [16:0] idata;
  logic        stall;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic [16:0] instr;
  logic [15:0] instr_pc;
  logic        instr_valid;
  logic [15:0] fetch_count;

  modport master (
    output iaddr,
    input  idata,
    input  stall,
    input  redirect,
    input  redirect_pc,
    output instr,
    output instr_pc,
    output instr_valid,
    output fetch_count
  );

  modport slave (
    input  iaddr,
    output idata,
    output stall,
    output redirect,
    output redirect_pc,
    input  instr,
    input  instr_pc,
    input  instr_valid,
    input  fetch_count
  );
endinterface

// File: rtl/imem_fetch.sv
// Instruction-fetch stage: owns the PC, registers each IM word into the
// instruction register, resolves absolute jumps locally, obeys stall/redirect.
module imem_fetch #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter logic [3:0]  JMP_OPC  = 4'd8
) (
  input  logic         clock,
  input  logic         reset,
  imem_fetch_if.master bus
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_HOLD  = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  typedef struct packed {
    logic [15:0] pc;
    logic [16:0] instr;
    logic [15:0] instr_pc;
    logic        valid;
    logic [15:0] count;
  } fetch_regs_t;

  localparam fetch_regs_t REGS_RESET = '{
    pc:       RESET_PC & 16'hFFFE,
    instr:    17'd0,
    instr_pc: 16'd0,
    valid:    1'b0,
    count:    16'd0
  };

  state_t      state_q, state_d;
  fetch_regs_t regs_q, regs_d;
  logic        is_jump;
  logic [15:0] jump_target;
  logic [15:0] seq_pc;

  // Jumps carry a 13-bit word target; shift it to a byte address.
  assign is_jump     = (bus.idata[16:13] == JMP_OPC);
  assign jump_target = {2'b00, bus.idata[12:0], 1'b0};
  assign seq_pc      = regs_q.pc + 16'd2;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values; the async reset clears them without waiting for a clock.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_RUN;
      regs_q  <= REGS_RESET;
    end else begin
      state_q <= state_d;
      regs_q  <= regs_d;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    regs_d  = regs_q;

    if (bus.redirect) begin
      // A taken branch wins over stall and over any jump in flight.
      regs_d.pc    = bus.redirect_pc & 16'hFFFE;
      regs_d.instr = 17'd0;
      regs_d.valid = 1'b0;
      state_d      = ST_FLUSH;
    end else if (bus.stall) begin
      state_d = ST_HOLD;
    end else begin
      regs_d.instr    = bus.idata;
      regs_d.instr_pc = regs_q.pc;
      regs_d.valid    = 1'b1;
      regs_d.count    = regs_q.count + 16'd1;
      regs_d.pc       = is_jump ? jump_target : seq_pc;
      state_d         = ST_RUN;
    end
  end

  assign bus.iaddr       = regs_q.pc;
  assign bus.instr       = regs_q.instr;
  assign bus.instr_pc    = regs_q.instr_pc;
  assign bus.instr_valid = regs_q.valid;
  assign bus.fetch_count = regs_q.count;

  // The flush bubble must never present a live instruction to decode.
  a_flush_bubble : assert property (
    @(posedge clock) disable iff (reset) (state_q == ST_FLUSH) |-> !regs_q.valid
  );

  a_iaddr_aligned : assert property (
    @(posedge clock) disable iff (reset) regs_q.pc[0] == 1'b0
  );

endmodule

// File: tb/tb_imem_fetch.sv
// Directed bench for imem_fetch: a per-cycle vector table plus hand-written
// sequences for async reset, back-to-back redirects and counter wrap.
module tb_imem_fetch;

  localparam logic [16:0] NOP = 17'h0C102;  // {4'd6,3'd0,3'd2,7'd2}
  localparam logic [16:0] JMP = 17'h10002;  // {4'd8,13'd2} -> byte 4

  logic clock;
  logic reset;
  imem_fetch_if bus ();

  imem_fetch #(.RESET_PC(16'h0000), .JMP_OPC(4'd8)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  logic [16:0] imem [64];
  assign bus.idata = imem[bus.iaddr[6:1]];

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic        stall;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic [15:0] e_iaddr;
    logic [16:0] e_instr;
    logic [15:0] e_instr_pc;
    logic        e_valid;
    logic [15:0] e_count;
  } vec_t;

  vec_t vecs[17];
  int   n_pass  = 0;
  int   n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, want %h", name, act, exp);
  endtask

  task automatic check_all(input string tag, input logic [15:0] ia, input logic [16:0] in,
                           input logic [15:0] ipc, input logic v, input logic [15:0] cnt);
    check({tag, " iaddr"},       {16'd0, bus.iaddr},       {16'd0, ia});
    check({tag, " instr"},       {15'd0, bus.instr},       {15'd0, in});
    check({tag, " instr_pc"},    {16'd0, bus.instr_pc},    {16'd0, ipc});
    check({tag, " instr_valid"}, {31'd0, bus.instr_valid}, {31'd0, v});
    check({tag, " fetch_count"}, {16'd0, bus.fetch_count}, {16'd0, cnt});
  endtask

  task automatic drive(input logic s, input logic r, input logic [15:0] rpc);
    bus.stall       = s;
    bus.redirect    = r;
    bus.redirect_pc = rpc;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) imem[i] = NOP;
    imem[5] = JMP;  // byte address 10

    //            stall redir rpc       iaddr     instr ipc       v     cnt
    vecs[0]  = '{1'b0, 1'b0, 16'h0000, 16'h0002, NOP,  16'h0000, 1'b1, 16'd1};
    vecs[1]  = '{1'b0, 1'b0, 16'h0000, 16'h0004, NOP,  16'h0002, 1'b1, 16'd2};
    vecs[2]  = '{1'b0, 1'b0, 16'h0000, 16'h0006, NOP,  16'h0004, 1'b1, 16'd3};
    vecs[3]  = '{1'b1, 1'b0, 16'h0000, 16'h0006, NOP,  16'h0004, 1'b1, 16'd3};
    vecs[4]  = '{1'b1, 1'b0, 16'h0000, 16'h0006, NOP,  16'h0004, 1'b1, 16'd3};
    vecs[5]  = '{1'b1, 1'b0, 16'h0000, 16'h0006, NOP,  16'h0004, 1'b1, 16'd3};
    vecs[6]  = '{1'b0, 1'b0, 16'h0000, 16'h0008, NOP,  16'h0006, 1'b1, 16'd4};
    vecs[7]  = '{1'b0, 1'b0, 16'h0000, 16'h000A, NOP,  16'h0008, 1'b1, 16'd5};
    vecs[8]  = '{1'b0, 1'b0, 16'h0000, 16'h0004, JMP,  16'h000A, 1'b1, 16'd6};
    vecs[9]  = '{1'b0, 1'b0, 16'h0000, 16'h0006, NOP,  16'h0004, 1'b1, 16'd7};
    vecs[10] = '{1'b1, 1'b1, 16'h0005, 16'h0004, 17'd0,16'h0004, 1'b0, 16'd7};
    vecs[11] = '{1'b0, 1'b0, 16'h0000, 16'h0006, NOP,  16'h0004, 1'b1, 16'd8};
    vecs[12] = '{1'b0, 1'b1, 16'hFFFF, 16'hFFFE, 17'd0,16'h0004, 1'b0, 16'd8};
    vecs[13] = '{1'b0, 1'b0, 16'h0000, 16'h0000, NOP,  16'hFFFE, 1'b1, 16'd9};
    vecs[14] = '{1'b0, 1'b0, 16'h0000, 16'h0002, NOP,  16'h0000, 1'b1, 16'd10};
    vecs[15] = '{1'b0, 1'b0, 16'h0000, 16'h0004, NOP,  16'h0002, 1'b1, 16'd11};
    vecs[16] = '{1'b1, 1'b0, 16'h0000, 16'h0004, NOP,  16'h0002, 1'b1, 16'd11};

    drive(1'b0, 1'b0, 16'h0000);
    reset = 1'b1;
    @(negedge clock);
    @(negedge clock);
    check_all("reset", 16'h0000, 17'd0, 16'h0000, 1'b0, 16'd0);
    reset = 1'b0;

    for (int i = 0; i < 17; i++) begin
      drive(vecs[i].stall, vecs[i].redirect, vecs[i].redirect_pc);
      @(negedge clock);
      check_all($sformatf("row%0d", i), vecs[i].e_iaddr, vecs[i].e_instr,
                vecs[i].e_instr_pc, vecs[i].e_valid, vecs[i].e_count);
    end

    // Asynchronous reset while in HOLD, checked well before the next edge.
    #2 reset = 1'b1;
    #1 check_all("async_rst", 16'h0000, 17'd0, 16'h0000, 1'b0, 16'd0);
    @(negedge clock);
    check_all("rst_held", 16'h0000, 17'd0, 16'h0000, 1'b0, 16'd0);
    drive(1'b0, 1'b0, 16'h0000);
    reset = 1'b0;

    // Redirect to the jump word, then redirect again from FLUSH: the second
    // redirect must win over the jump sitting on idata.
    drive(1'b0, 1'b1, 16'h000A);
    @(negedge clock);
    check_all("redir_a", 16'h000A, 17'd0, 16'h0000, 1'b0, 16'd0);
    drive(1'b0, 1'b1, 16'h0031);
    @(negedge clock);
    check_all("redir_b", 16'h0030, 17'd0, 16'h0000, 1'b0, 16'd0);
    drive(1'b0, 1'b0, 16'h0000);
    @(negedge clock);
    check_all("after_flush", 16'h0032, NOP, 16'h0030, 1'b1, 16'd1);

    // fetch_count wraps at 16'hFFFF back to zero.
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    repeat (65535) @(negedge clock);
    check("count_ffff", {16'd0, bus.fetch_count}, 32'h0000FFFF);
    @(negedge clock);
    check("count_wrap", {16'd0, bus.fetch_count}, 32'h00000000);
    check("wrap_valid", {31'd0, bus.instr_valid}, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
